// File: rtl/mem_ack_responder.sv
// Word-addressed memory slave with a fixed ACK hold time per request.
// ACK doubles as the address-hold flag for the control-store incrementer.
module mem_ack_responder #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int LATENCY       = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     RD,
  input  logic                     WR,
  input  logic [31:0]              ADDRESS,
  input  logic [DATAWIDTH_BUS-1:0] DATAIN,
  output logic                     ACK,
  output logic [DATAWIDTH_BUS-1:0] DATAOUT,
  output logic                     ERR
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_ack_responder: LATENCY must be in 1..15");
  end

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_BUSY     = 2'd1;
  localparam logic [1:0] S_COMPLETE = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]               r_state;
  logic [3:0]               r_cnt;
  logic [31:0]              r_addr;
  logic [DATAWIDTH_BUS-1:0] r_data;
  logic                     r_wr;

  logic [DATAWIDTH_BUS-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

  logic [ADDR_WIDTH-1:0]    w_idx;
  logic [31:0]              w_hi;
  logic                     w_err;
  logic                     w_done;

  // Errors are judged on the captured address so mid-transfer input changes cannot affect them.
  always_comb begin
    w_idx  = r_addr[ADDR_WIDTH+1:2];
    w_hi   = r_addr >> (ADDR_WIDTH + 2);
    w_err  = (r_addr[1:0] != 2'b00) || (w_hi != '0);
    w_done = !RESET && (r_state == S_BUSY) && (r_cnt == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      ACK     <= 1'b0;
      DATAOUT <= '0;
      ERR     <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (RD ^ WR) begin
            r_addr  <= ADDRESS;
            r_data  <= DATAIN;
            r_wr    <= WR;
            r_cnt   <= LAT_M1;
            ACK     <= 1'b1;
            r_state <= S_BUSY;
          end else if (RD && WR) begin
            ERR <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            ACK     <= 1'b0;
            r_state <= S_COMPLETE;
            if (w_err) begin
              ERR <= 1'b1;
              if (!r_wr) DATAOUT <= '0;
            end else if (!r_wr) begin
              DATAOUT <= r_mem[w_idx];
            end
          end
        end
        S_COMPLETE: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; reset only blocks the write.
  always_ff @(posedge CLK) begin
    if (w_done && r_wr && !w_err) r_mem[w_idx] <= r_data;
  end

endmodule

// File: doc/mem_ack_responder.md
MEM_ACK_RESPONDER -- requirements
Module: mem_ack_responder

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, SHALL set the data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width, giving 2^ADDR_WIDTH words of storage.
REQ-003 Parameter LATENCY, default 3, legal range 1..15, SHALL set the number of cycles ACK is held high per request.
REQ-004 CLK  input  1  clock; all state SHALL update on its rising edge only.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 RD  input  1  read request from the microcontroller.
REQ-007 WR  input  1  write request from the microcontroller.
REQ-008 ADDRESS  input  32  byte address of the transfer.
REQ-009 DATAIN  input  DATAWIDTH_BUS  write data.
REQ-010 ACK  output  1  registered wait/hold flag to the control-store address incrementer: 1 = transfer in progress (hold address), 0 = advance.
REQ-011 DATAOUT  output  DATAWIDTH_BUS  registered read data.
REQ-012 ERR  output  1  registered one-cycle error pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, COMPLETE.
REQ-014 In IDLE with exactly one of RD or WR high at an edge, the block SHALL capture ADDRESS, DATAIN and the request type, load the counter with LATENCY-1, set ACK to 1, and go to BUSY.
REQ-015 In IDLE with RD=WR=1 at an edge, the block SHALL ignore the request, keep ACK at 0, stay in IDLE, and pulse ERR for one cycle.
REQ-016 In BUSY with counter != 0, the block SHALL decrement the counter and hold ACK at 1; RD, WR, ADDRESS and DATAIN SHALL be ignored.
REQ-017 In BUSY with counter == 0, the block SHALL perform the access, set ACK to 0 and go to COMPLETE.
REQ-018 ACK SHALL therefore be high for exactly LATENCY cycles per accepted request; a request sampled at edge k completes at edge k+LATENCY.
REQ-019 A read completion SHALL load DATAOUT with mem[captured ADDRESS[ADDR_WIDTH+1:2]].
REQ-020 A write completion SHALL store captured DATAIN to that word and SHALL leave DATAOUT unchanged.
REQ-021 COMPLETE SHALL last one cycle, SHALL ignore RD/WR (the requester's microinstruction is still present), and SHALL return to IDLE.
REQ-022 A captured ADDRESS with ADDRESS[1:0] != 0 SHALL be an error (misaligned).
REQ-023 A captured ADDRESS with any bit of ADDRESS[31:ADDR_WIDTH+2] set SHALL be an error (out of range).
REQ-024 An erroneous request SHALL still run the full BUSY timing with ACK high, SHALL perform no memory write, SHALL set DATAOUT to 0 if it is a read, and SHALL pulse ERR in the cycle after completion.
REQ-025 ERR SHALL be 0 in every cycle not named in REQ-015 or REQ-024.
REQ-026 The earliest next accepted request SHALL be sampled at edge k+LATENCY+2 (the first edge in IDLE).

Reset
REQ-027 RESET=1 at an edge SHALL force state IDLE, ACK=0, DATAOUT=0, ERR=0 and counter=0, overriding all other inputs.
REQ-028 Reset during BUSY SHALL abort the transfer: no memory write, no DATAOUT update.
REQ-029 Memory contents SHALL NOT be cleared by reset; reads of never-written words return undefined data.

Verification
REQ-030 LATENCY=3: WR=1, ADDRESS=0x10, DATAIN=0xDEADBEEF, then RD at 0x10 -> ACK high exactly 3 cycles for each request, DATAOUT=0xDEADBEEF one edge after ACK falls, ERR=0 throughout.
REQ-031 LATENCY=1: back-to-back reads held continuously high -> ACK pattern 1,0,0,1,0,0,... (IDLE, BUSY, COMPLETE per request), one access per 3 cycles.
REQ-032 RD=WR=1 in IDLE -> ACK stays 0, ERR=1 for one cycle, memory unchanged.
REQ-033 RD at ADDRESS=0x12 and at 0x400 (ADDR_WIDTH=8) -> full ACK timing, DATAOUT=0, ERR pulse after each completion; WR at 0x400 leaves word 0 unchanged.
REQ-034 RESET asserted in the 2nd BUSY cycle of WR to 0x20 with DATAIN=0x1 (word 0x20 previously 0x5) -> ACK=0 next cycle, later read of 0x20 returns 0x5.
REQ-035 Inputs changed during BUSY (ADDRESS, DATAIN, RD/WR) -> access uses the values captured at the request edge.
